// File: rtl/adder_pkg.sv
// Shared constants for the operand pair adder: parameter defaults and the
// FSM state encoding.
package adder_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // FSM state encoding
  localparam logic [1:0] WAIT_A = 2'd0;  // waiting for the first operand
  localparam logic [1:0] WAIT_B = 2'd1;  // a captured, waiting for the second
  localparam logic [1:0] HOLD   = 2'd2;  // result presented, waiting for consumer

endpackage

// File: rtl/adder_core.sv
// Purely combinational WIDTH-bit adder with carry-out; no state.
module adder_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Zero-extend both operands so the extra bit catches the carry-out
  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/operand_pair_adder.sv
// Collects two operands from a single valid/ready stream (a then b),
// presents {carry, a+b} on a valid/ready output and counts delivered results.
//
// Handshake semantics (both ports): a beat transfers on a rising clk edge
// where valid and ready are both high; valid never depends on ready, and
// a presented result (out_sum/out_carry) stays stable until it transfers.
module operand_pair_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] pair_count,
  output logic [1:0]       dbg_state
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign dbg_state = state;

  adder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a_q),
    .b     (in_data),
    .sum   (core_sum),
    .carry (core_carry)
  );

  // Next-state logic; clear wins over any simultaneous handshake
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = WAIT_A;
    end else begin
      case (state)
        WAIT_A:  if (in_xfer)  state_nxt = WAIT_B;
        WAIT_B:  if (in_xfer)  state_nxt = HOLD;
        HOLD:    if (out_xfer) state_nxt = WAIT_A;
        default:               state_nxt = WAIT_A;
      endcase
    end
  end

  // State plus registered handshake outputs; both are low during reset, so
  // in_ready only rises on the first edge after rst_n is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_A;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != HOLD);
      out_valid <= (state_nxt == HOLD);
    end
  end

  // Operand and result capture; out_sum/out_carry keep their value outside HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (!clear && in_xfer) begin
      if (state == WAIT_A) begin
        a_q <= in_data;
      end else if (state == WAIT_B) begin
        out_sum   <= core_sum;
        out_carry <= core_carry;
      end
    end
  end

  // Delivered-result counter; wraps naturally, frozen by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
    end else if (!clear && (state == HOLD) && out_xfer) begin
      pair_count <= pair_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_pair_adder.sv
// Directed bench for operand_pair_adder. Inputs change just after the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
// A second instance with CNT_W = 2 shares the stimulus for the wrap test.
module tb_operand_pair_adder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_data   = 8'd0;
  logic        out_ready = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_sum;
  logic        out_carry;
  logic [15:0] pair_count;
  logic [1:0]  dbg_state;

  logic        in_ready2;
  logic        out_valid2;
  logic [7:0]  out_sum2;
  logic        out_carry2;
  logic [1:0]  pair_count2;
  logic [1:0]  dbg_state2;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_WAIT_A = 2'd0;

  operand_pair_adder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_carry  (out_carry),
    .pair_count (pair_count),
    .dbg_state  (dbg_state)
  );

  operand_pair_adder #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_data    (in_data),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_sum    (out_sum2),
    .out_carry  (out_carry2),
    .pair_count (pair_count2),
    .dbg_state  (dbg_state2)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_carry, pair_count} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b sum=%0d c=%0b cnt=%0d, need all 0",
               in_ready, out_valid, out_sum, out_carry, pair_count);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready: got %0b need 0 before first edge", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== S_WAIT_A) begin
      failures++;
      $display("FAIL reset_first_edge: got rdy=%0b vld=%0b st=%0d need 1 0 0",
               in_ready, out_valid, dbg_state);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_beat(8'd3);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_a: got vld=%0b rdy=%0b need 0 1", out_valid, in_ready);
    end
    send_beat(8'd2);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_carry !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got vld=%0b sum=%0d c=%0b need 1 5 0",
               out_valid, out_sum, out_carry);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || pair_count !== 16'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_delivered: got vld=%0b cnt=%0d rdy=%0b need 0 1 1",
               out_valid, pair_count, in_ready);
    end
  endtask

  task automatic test_carry();
    out_ready = 1'b1;
    send_beat(8'd200);
    send_beat(8'd100);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd44 || out_carry !== 1'b1) begin
      failures++;
      $display("FAIL carry_result: got vld=%0b sum=%0d c=%0b need 1 44 1",
               out_valid, out_sum, out_carry);
    end
    step();
    checks++;
    if (pair_count !== 16'd2) begin
      failures++;
      $display("FAIL carry_count: got %0d need 2", pair_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_beat(8'd7);
    send_beat(8'd12);
    // Offer a stray beat during HOLD; it must not be taken
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 8'd19 || out_carry !== 1'b0 ||
          in_ready !== 1'b0 || pair_count !== 16'd2) begin
        failures++;
        $display("FAIL hold_cycle%0d: got vld=%0b sum=%0d c=%0b rdy=%0b cnt=%0d need 1 19 0 0 2",
                 i, out_valid, out_sum, out_carry, in_ready, pair_count);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (pair_count !== 16'd3 || out_valid !== 1'b0 || dbg_state !== S_WAIT_A) begin
      failures++;
      $display("FAIL hold_release: got cnt=%0d vld=%0b st=%0d need 3 0 0",
               pair_count, out_valid, dbg_state);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send_beat(8'd9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (dbg_state !== S_WAIT_A || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_partial: got st=%0d rdy=%0b need 0 1", dbg_state, in_ready);
    end
    send_beat(8'd1);
    send_beat(8'd1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd2 || out_carry !== 1'b0) begin
      failures++;
      $display("FAIL clear_result: got vld=%0b sum=%0d c=%0b need 1 2 0",
               out_valid, out_sum, out_carry);
    end
    step();
    checks++;
    if (pair_count !== 16'd4) begin
      failures++;
      $display("FAIL clear_count: got %0d need 4", pair_count);
    end
    // Clear against an output handshake in HOLD
    out_ready = 1'b0;
    send_beat(8'd5);
    send_beat(8'd6);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd11) begin
      failures++;
      $display("FAIL clear_hold_setup: got vld=%0b sum=%0d need 1 11", out_valid, out_sum);
    end
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pair_count !== 16'd4 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_hold: got vld=%0b cnt=%0d rdy=%0b need 0 4 1",
               out_valid, pair_count, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send_beat(8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_carry, pair_count} !== 27'd0) begin
      failures++;
      $display("FAIL reset_wait_b: got rdy=%0b vld=%0b sum=%0d c=%0b cnt=%0d need all 0",
               in_ready, out_valid, out_sum, out_carry, pair_count);
    end
    step();
    rst_n = 1'b1;
    step();
    send_beat(8'd1);
    send_beat(8'd2);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd3) begin
      failures++;
      $display("FAIL reset_hold_setup: got vld=%0b sum=%0d need 1 3", out_valid, out_sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_carry, pair_count} !== 27'd0) begin
      failures++;
      $display("FAIL reset_hold: got rdy=%0b vld=%0b sum=%0d c=%0b cnt=%0d need all 0",
               in_ready, out_valid, out_sum, out_carry, pair_count);
    end
    step();
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send_beat(8'd4);
    send_beat(8'd4);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd8 || out_carry !== 1'b0) begin
      failures++;
      $display("FAIL reset_next_pair: got vld=%0b sum=%0d c=%0b need 1 8 0",
               out_valid, out_sum, out_carry);
    end
    step();
    checks++;
    if (pair_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_next_count: got %0d need 1", pair_count);
    end
  endtask

  task automatic test_count_wrap();
    logic [1:0]  exp_small [5];
    logic [7:0]  sum_exp;
    exp_small = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat(8'(i + 10));
      send_beat(8'd1);
      sum_exp = 8'(i + 11);
      checks++;
      if (out_valid2 !== 1'b1 || out_sum2 !== sum_exp) begin
        failures++;
        $display("FAIL wrap_sum%0d: got vld=%0b sum=%0d need 1 %0d",
                 i, out_valid2, out_sum2, sum_exp);
      end
      step();
      checks++;
      if (pair_count2 !== exp_small[i] || pair_count !== 16'(i + 1)) begin
        failures++;
        $display("FAIL wrap_count%0d: got small=%0d wide=%0d need %0d %0d",
                 i, pair_count2, pair_count, exp_small[i], i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_pair_adder.md
OPERAND_PAIR_ADDER -- requirements
Module: operand_pair_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, giving the pair-counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clear, input, 1 bit: synchronous abort of any partial pair.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: operand byte stream; first beat is a, second is b.
REQ-009 SHALL have port out_valid, output, 1 bit: out_sum and out_carry are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_sum, output, WIDTH bits: (a + b) mod 2^WIDTH.
REQ-012 SHALL have port out_carry, output, 1 bit: carry-out of a + b.
REQ-013 SHALL have port pair_count, output, CNT_W bits: number of results delivered.

Function
REQ-014 SHALL implement an FSM with states WAIT_A, WAIT_B and HOLD; the reset state is WAIT_A.
REQ-015 SHALL drive in_ready = 1 in WAIT_A and WAIT_B and in_ready = 0 in HOLD; out_valid = 1 only in HOLD.
REQ-016 SHALL count a transfer only when in_valid and in_ready are both high in the same cycle.
REQ-017 On a transfer in WAIT_A, SHALL register in_data as a and move to WAIT_B.
REQ-018 On a transfer in WAIT_B, SHALL register the full (WIDTH+1)-bit sum {carry, a + in_data} and move to HOLD, so out_valid rises exactly 1 cycle after b is accepted.
REQ-019 SHALL hold out_sum and out_carry stable in HOLD until out_valid and out_ready are both high in the same cycle.
REQ-020 When that output handshake completes, SHALL return to WAIT_A, increment pair_count by 1 (wrapping from all-ones to 0), and not accept in_data in the same cycle.
REQ-021 SHALL hold state with no side effects when in_valid = 0 in WAIT_A or WAIT_B.
REQ-022 When clear = 1, SHALL go to WAIT_A and discard any captured a or pending result; clear overrides every simultaneous in_data or output handshake, and pair_count is not incremented.
REQ-023 SHALL leave pair_count unchanged when clear is asserted.
REQ-024 SHALL keep out_sum and out_carry at their last value outside HOLD; they carry no meaning while out_valid = 0.

Reset
REQ-025 While rst_n = 0, SHALL immediately (asynchronously) force: state WAIT_A, a = 0, out_sum = 0, out_carry = 0, pair_count = 0, out_valid = 0, in_ready = 0.
REQ-026 SHALL raise in_ready on the first rising clk edge after rst_n is released.
REQ-027 Reset asserted during operation SHALL abandon any partial pair or undelivered result with no output handshake.

Structure
REQ-028 SHALL take the FSM state encoding (WAIT_A, WAIT_B, HOLD) and the WIDTH/CNT_W defaults from a shared package, adder_pkg.
REQ-029 SHALL instantiate exactly one sub-module, adder_core: a purely combinational WIDTH-bit adder with carry-out; all registers stay in operand_pair_adder.

Verification
REQ-030 Bench SHALL feed in_data 3 then 2 with out_ready = 1 and check: out_sum = 5, out_carry = 0, out_valid rises 1 cycle after b, pair_count = 1.
REQ-031 Bench SHALL feed 200 then 100 and check: out_sum = 44, out_carry = 1.
REQ-032 Bench SHALL feed 7 then 12 with out_ready = 0 for 5 cycles and check: out_sum = 19 held stable, in_ready = 0 throughout, pair_count increments only on the cycle out_ready rises.
REQ-033 Bench SHALL feed 9, pulse clear, then feed 1 and 1 and check: result = 2 and the 9 is discarded; separately, assert clear together with out_ready in HOLD and check that no count increment occurs.
REQ-034 Bench SHALL drop rst_n mid-WAIT_B and mid-HOLD and check: all outputs are 0 immediately, and the next pair 4+4 gives 8.
REQ-035 Bench SHALL run with CNT_W = 2 for 5 pairs and check that pair_count reads 1,2,3,0,1.
